// File: rtl/fifo_mr_seq.sv
// Tile sequencer for the shared-write, multi-read PE FIFO: clears the FIFO,
// admits tile_len words, turns per-reader requests into pops, pulses done.
module fifo_mr_seq #(
   parameter int unsigned RD_NUM    = 4,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] tile_len,
   output logic                 busy,
   output logic                 done,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 fifo_reset,
   output logic                 fifo_push,
   input  logic                 fifo_full,
   input  logic [RD_NUM-1:0]    fifo_empty,
   output logic [RD_NUM-1:0]    fifo_pop,
   input  logic [RD_NUM-1:0]    rd_req,
   output logic [RD_NUM-1:0]    rd_valid
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
   logic [LEN_WIDTH-1:0]  rd_cnt_q [RD_NUM];
   logic [LEN_WIDTH-1:0]  rd_cnt_d [RD_NUM];
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  fifo_reset_q, fifo_reset_d;
   logic [RD_NUM-1:0]     rd_valid_q, rd_valid_d;

   logic                  run_c;
   logic                  wr_open_c;
   logic                  push_c;
   logic                  all_rd_done_c;
   logic [RD_NUM-1:0]     pop_c;

   // Write side: admit words until len_q have been pushed, honouring full.
   always_comb begin
      run_c     = (state_q == S_RUN);
      wr_open_c = (wr_cnt_q != len_q);
      push_c    = run_c && wr_open_c && !fifo_full && in_valid;
   end

   // Read side: each reader pops independently until it has len_q words.
   always_comb begin
      pop_c         = '0;
      all_rd_done_c = 1'b1;
      for (int i = 0; i < int'(RD_NUM); i++) begin
         pop_c[i] = run_c && rd_req[i] && !fifo_empty[i] && (rd_cnt_q[i] != len_q);
         if (rd_cnt_q[i] != len_q) begin
            all_rd_done_c = 1'b0;
         end
      end
   end

   // Word counters, cleared in CLEAR so a new tile starts from zero.
   always_comb begin
      wr_cnt_d = wr_cnt_q;
      for (int i = 0; i < int'(RD_NUM); i++) begin
         rd_cnt_d[i] = rd_cnt_q[i];
      end
      if (state_q == S_CLEAR) begin
         wr_cnt_d = '0;
         for (int i = 0; i < int'(RD_NUM); i++) begin
            rd_cnt_d[i] = '0;
         end
      end else begin
         if (push_c) begin
            wr_cnt_d = wr_cnt_q + LEN_WIDTH'(1);
         end
         for (int i = 0; i < int'(RD_NUM); i++) begin
            if (pop_c[i]) begin
               rd_cnt_d[i] = rd_cnt_q[i] + LEN_WIDTH'(1);
            end
         end
      end
   end

   // Next state and registered output decode.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      fifo_reset_d = 1'b0;
      rd_valid_d   = pop_c;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = tile_len;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = (len_q == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (!wr_open_c && all_rd_done_c) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d       = (state_d == S_CLEAR) || (state_d == S_RUN);
      done_d       = (state_d == S_DONE);
      fifo_reset_d = (state_d == S_CLEAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         wr_cnt_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fifo_reset_q <= 1'b0;
         rd_valid_q   <= '0;
         for (int i = 0; i < int'(RD_NUM); i++) begin
            rd_cnt_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         wr_cnt_q     <= wr_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fifo_reset_q <= fifo_reset_d;
         rd_valid_q   <= rd_valid_d;
         for (int i = 0; i < int'(RD_NUM); i++) begin
            rd_cnt_q[i] <= rd_cnt_d[i];
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign fifo_reset = fifo_reset_q;
   assign rd_valid   = rd_valid_q;
   assign in_ready   = run_c && wr_open_c && !fifo_full;
   assign fifo_push  = push_c;
   assign fifo_pop   = pop_c;

endmodule

// File: tb/tb_fifo_mr_seq.sv
// Bench for fifo_mr_seq: a 16-deep multi-read FIFO model, a tile-level
// reference model checked every cycle, and directed tile scenarios.
module tb_fifo_mr_seq;
   localparam int unsigned RD    = 4;
   localparam int unsigned LW    = 16;
   localparam int          DEPTH = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start;
   logic [LW-1:0] tile_len;
   logic          busy, done, in_valid, in_ready;
   logic          fifo_reset, fifo_push, fifo_full;
   logic [RD-1:0] fifo_empty, fifo_pop, rd_req, rd_valid;

   always #5 clk = ~clk;

   fifo_mr_seq #(.RD_NUM(RD), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tile_len(tile_len),
      .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
      .fifo_reset(fifo_reset), .fifo_push(fifo_push), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .rd_req(rd_req),
      .rd_valid(rd_valid)
   );

   int n_vec = 0;
   int n_err = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Multi-read FIFO: one write pointer, one read pointer per reader;
   // words stored are their index within the tile.
   logic [31:0] mem [DEPTH];
   int          wp = 0;
   int          rp [RD] = '{default: 0};
   logic [31:0] dout [RD] = '{default: 32'd0};
   int          min_rp;

   always_comb begin
      min_rp = rp[0];
      for (int i = 1; i < int'(RD); i++) if (rp[i] < min_rp) min_rp = rp[i];
      fifo_full = ((wp - min_rp) >= DEPTH);
      for (int i = 0; i < int'(RD); i++) fifo_empty[i] = (rp[i] == wp);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || fifo_reset) begin
         wp <= 0;
         for (int i = 0; i < int'(RD); i++) rp[i] <= 0;
      end else begin
         if (fifo_push) begin
            mem[wp % DEPTH] <= 32'(wp);
            wp <= wp + 1;
         end
         for (int i = 0; i < int'(RD); i++) begin
            if (fifo_pop[i]) begin
               dout[i] <= mem[rp[i] % DEPTH];
               rp[i]   <= rp[i] + 1;
            end
         end
      end
   end

   // Tile-level reference model.
   typedef enum int {M_IDLE, M_CLEAR, M_RUN, M_DONE} mph_e;
   mph_e          ph = M_IDLE;
   int            m_len = 0;
   int            m_wr = 0;
   int            m_rd [RD] = '{default: 0};
   logic [RD-1:0] m_prev_pop = '0;
   logic [RD-1:0] m_p;
   logic          m_w;
   logic          m_all;

   function automatic logic exp_in_ready();
      return (ph == M_RUN) && (m_wr < m_len) && !fifo_full;
   endfunction

   function automatic logic [RD-1:0] exp_pop();
      logic [RD-1:0] p;
      p = '0;
      for (int i = 0; i < int'(RD); i++)
         p[i] = (ph == M_RUN) && rd_req[i] && !fifo_empty[i] && (m_rd[i] < m_len);
      return p;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = M_IDLE; m_len = 0; m_wr = 0; m_prev_pop = '0;
         for (int i = 0; i < int'(RD); i++) m_rd[i] = 0;
      end else begin
         m_p = exp_pop();
         m_w = exp_in_ready() && in_valid;
         m_prev_pop = m_p;
         case (ph)
            M_IDLE: if (start) begin m_len = int'(tile_len); ph = M_CLEAR; end
            M_CLEAR: begin
               m_wr = 0;
               for (int i = 0; i < int'(RD); i++) m_rd[i] = 0;
               ph = (m_len == 0) ? M_DONE : M_RUN;
            end
            M_RUN: begin
               m_all = 1'b1;
               for (int i = 0; i < int'(RD); i++) if (m_rd[i] != m_len) m_all = 1'b0;
               if (m_wr == m_len && m_all) ph = M_DONE;
               if (m_w) m_wr++;
               for (int i = 0; i < int'(RD); i++) if (m_p[i]) m_rd[i]++;
            end
            default: ph = M_IDLE;
         endcase
      end
   end

   // Per-cycle compare plus observation counters.
   int gcyc = 0;
   int push_cnt = 0, done_cnt = 0, busy_cyc = 0, clr_cyc = 0;
   int pop_cnt [RD] = '{default: 0};
   int rdv_cnt [RD] = '{default: 0};
   int exp_data [RD] = '{default: 0};
   int last_rdv_cyc = 0, done_cyc = 0;

   always @(negedge clk) begin
      check("busy",       32'(busy),       32'(ph == M_CLEAR || ph == M_RUN));
      check("done",       32'(done),       32'(ph == M_DONE));
      check("fifo_reset", 32'(fifo_reset), 32'(ph == M_CLEAR));
      check("in_ready",   32'(in_ready),   32'(exp_in_ready()));
      check("fifo_push",  32'(fifo_push),  32'(exp_in_ready() && in_valid));
      check("fifo_pop",   32'(fifo_pop),   32'(exp_pop()));
      check("rd_valid",   32'(rd_valid),   32'(m_prev_pop));
      check("pop_on_empty", 32'(fifo_pop & fifo_empty), 32'd0);
      for (int i = 0; i < int'(RD); i++) begin
         if (rd_valid[i]) begin
            check($sformatf("data%0d", i), dout[i], 32'(exp_data[i]));
            exp_data[i]++;
            rdv_cnt[i]++;
            last_rdv_cyc = gcyc;
         end
         if (fifo_pop[i]) pop_cnt[i]++;
         if (!rst_n || ph == M_CLEAR) exp_data[i] = 0;
      end
      if (fifo_push) push_cnt++;
      if (done) begin done_cnt++; done_cyc = gcyc; end
      if (busy) busy_cyc++;
      if (fifo_reset) clr_cyc++;
      gcyc++;
   end

   // Upstream / reader stimulus.
   int mode = 0;
   int tile_start_cyc = 0;

   initial begin
      in_valid = 1'b0;
      rd_req   = '0;
      forever begin
         @(posedge clk); #1;
         case (mode)
            1: begin
               in_valid = 1'b1;
               rd_req   = ((gcyc - tile_start_cyc) < 30) ? 4'b0111 : 4'b1111;
            end
            2: begin
               in_valid = 1'($urandom_range(0, 1));
               rd_req   = RD'($urandom_range(0, 15));
            end
            default: begin
               in_valid = 1'b1;
               rd_req   = '1;
            end
         endcase
      end
   end

   task automatic begin_tile(input int len);
      @(posedge clk); #1;
      push_cnt = 0; done_cnt = 0; busy_cyc = 0; clr_cyc = 0;
      for (int i = 0; i < int'(RD); i++) begin pop_cnt[i] = 0; rdv_cnt[i] = 0; end
      tile_len = LW'(len);
      start = 1'b1;
      tile_start_cyc = gcyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (done) break;
      end
      check("done_seen", 32'(done), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_tile(input string tag, input int len);
      check({tag, "_pushes"}, 32'(push_cnt), 32'(len));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      for (int i = 0; i < int'(RD); i++) begin
         check($sformatf("%s_pops%0d", tag, i), 32'(pop_cnt[i]), 32'(len));
         check($sformatf("%s_rdv%0d", tag, i), 32'(rdv_cnt[i]), 32'(len));
      end
   endtask

   initial begin
      start    = 1'b0;
      tile_len = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Full-rate tile of 8.
      mode = 0;
      begin_tile(8);
      wait_done();
      check_tile("t8", 8);
      check("t8_busy_cycles", 32'(busy_cyc), 32'd11);
      check("t8_clear_cycles", 32'(clr_cyc), 32'd1);
      check("t8_done_after_rdv", 32'(done_cyc - last_rdv_cyc), 32'd1);

      // Slow reader 3 stalls the writer at 16 words.
      mode = 1;
      begin_tile(20);
      repeat (24) @(negedge clk);
      check("t20_mid_pushes", 32'(push_cnt), 32'd16);
      check("t20_mid_in_ready", 32'(in_ready), 32'd0);
      check("t20_mid_full", 32'(fifo_full), 32'd1);
      check("t20_mid_done", 32'(done_cnt), 32'd0);
      check("t20_mid_rdv3", 32'(rdv_cnt[3]), 32'd0);
      wait_done();
      check_tile("t20", 20);

      // Empty tile.
      mode = 0;
      begin_tile(0);
      wait_done();
      check_tile("t0", 0);
      check("t0_busy_cycles", 32'(busy_cyc), 32'd1);
      check("t0_clear_cycles", 32'(clr_cyc), 32'd1);

      // Random requests and upstream gaps.
      mode = 2;
      begin_tile(100);
      wait_done();
      check_tile("t100", 100);

      // start during RUN and during DONE is ignored.
      mode = 0;
      begin_tile(8);
      repeat (4) @(posedge clk);
      #1; start = 1'b1; tile_len = LW'(3);
      @(posedge clk); #1; start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (done) begin
            start = 1'b1; tile_len = LW'(7);
            @(posedge clk); #1; start = 1'b0;
            break;
         end
      end
      repeat (4) @(negedge clk);
      check("ign_busy", 32'(busy), 32'd0);
      check_tile("ign", 8);
      check("ign_clear_cycles", 32'(clr_cyc), 32'd1);
      begin_tile(5);
      wait_done();
      check_tile("t5", 5);
      check("t5_clear_cycles", 32'(clr_cyc), 32'd1);

      // Reset mid-tile after 3 words, then a clean tile.
      begin_tile(8);
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (push_cnt == 3) break;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("mr_pushes_before", 32'(push_cnt), 32'd3);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_done", 32'(done), 32'd0);
      check("mr_in_ready", 32'(in_ready), 32'd0);
      check("mr_push", 32'(fifo_push), 32'd0);
      check("mr_pop", 32'(fifo_pop), 32'd0);
      check("mr_fifo_reset", 32'(fifo_reset), 32'd0);
      check("mr_rd_valid", 32'(rd_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      begin_tile(8);
      wait_done();
      check_tile("post_rst", 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
